// File: rtl/l15_resp_pkg.sv
// Shared encodings for the L1.5 responder stub: request/return types, sizes,
// FSM states and the big-endian <-> little-endian word swap.
package l15_resp_pkg;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] IMISS_RQ = 5'b10000;
  localparam logic [4:0] STORE_RQ = 5'b00001;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;

  typedef enum logic [2:0] {
    SIZE_1B  = 3'd0,
    SIZE_2B  = 3'd1,
    SIZE_4B  = 3'd2,
    SIZE_8B  = 3'd3,
    SIZE_16B = 3'd4
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT,
    RESP
  } state_e;

  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[8*(7-i) +: 8];
    end
    return r;
  endfunction

  // Naturally aligned byte lanes (little-endian lane numbering); misaligned low bits are masked.
  function automatic logic [7:0] byte_en(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] be;
    be = '1;
    case (size)
      SIZE_1B: be = 8'b0000_0001 << off;
      SIZE_2B: be = 8'b0000_0011 << {off[2:1], 1'b0};
      SIZE_4B: be = 8'b0000_1111 << {off[2], 2'b00};
      default: be = '1;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// Backing store for the L1.5 stub: even/odd 64-bit word banks sharing one row
// address, synchronous read of both banks, byte-enabled write to one bank.
module l15_resp_mem #(
  parameter int unsigned RowsLog2 = 13
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic                wr_odd,
  input  logic [RowsLog2-1:0] row,
  input  logic [7:0]          be,
  input  logic [63:0]         wdata,
  output logic [63:0]         rdata_even,
  output logic [63:0]         rdata_odd
);

  logic [63:0] mem_even [2**RowsLog2];
  logic [63:0] mem_odd  [2**RowsLog2];

  // Read registers only move on rd_en so the return data stays stable while held.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata_even <= mem_even[row];
      rdata_odd  <= mem_odd[row];
    end
    if (wr_en) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (be[b]) begin
          if (wr_odd) begin
            mem_odd[row][8*b +: 8] <= wdata[8*b +: 8];
          end else begin
            mem_even[row][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/l15_resp_stub.sv
// L1.5-side responder stub: services load/ifill/store from an internal memory.
// Define L15_RESP_DELAY_EN to insert RespDelay extra cycles before each return.
module l15_resp_stub
  import l15_resp_pkg::*;
#(
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned PAddrWidth   = 40,
  parameter int unsigned MemWordsLog2 = 14,
  parameter int unsigned RespDelay    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_val_i,
  output logic                  req_ack_o,
  input  logic [4:0]            req_rqtype_i,
  input  logic                  req_nc_i,
  input  logic [2:0]            req_size_i,
  input  logic [TidWidth-1:0]   req_threadid_i,
  input  logic [PAddrWidth-1:0] req_address_i,
  input  logic [63:0]           req_data_i,
  output logic                  rtrn_val_o,
  input  logic                  rtrn_ack_i,
  output logic [3:0]            rtrn_rtntype_o,
  output logic [TidWidth-1:0]   rtrn_threadid_o,
  output logic [63:0]           rtrn_data_0_o,
  output logic [63:0]           rtrn_data_1_o,
  output logic                  err_o
);

  state_e state, state_nxt;

  logic [4:0]            rqtype_q;
  logic                  nc_q;
  logic [2:0]            size_q;
  logic [TidWidth-1:0]   tid_q;
  logic [MemWordsLog2+2:0] addr_q;
  logic [63:0]           data_q;
  logic                  err_q;

  logic is_load, is_imiss, is_store, supported;
  logic [63:0] rdata_even, rdata_odd, word_sel;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_address_i[PAddrWidth-1:MemWordsLog2+3];

  assign is_load   = (rqtype_q == LOAD_RQ);
  assign is_imiss  = (rqtype_q == IMISS_RQ);
  assign is_store  = (rqtype_q == STORE_RQ);
  assign supported = is_load | is_imiss | is_store;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      err_q    <= 1'b0;
      rqtype_q <= '0;
      nc_q     <= 1'b0;
      size_q   <= '0;
      tid_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_val_i) begin
        rqtype_q <= req_rqtype_i;
        nc_q     <= req_nc_i;
        size_q   <= req_size_i;
        tid_q    <= req_threadid_i;
        addr_q   <= req_address_i[MemWordsLog2+2:0];
        data_q   <= req_data_i;
      end
      if (state == ACK && !supported) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef L15_RESP_DELAY_EN
  localparam int unsigned CntW = (RespDelay > 1) ? $clog2(RespDelay) : 1;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state == ACK) begin
      cnt_q <= CntW'(RespDelay - 1);
    end else if (state == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  logic [31:0] unused_resp_delay;
  assign unused_resp_delay = RespDelay;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_val_i) state_nxt = ACK;
      ACK: begin
        if (!supported) begin
          state_nxt = IDLE;
        end else begin
`ifdef L15_RESP_DELAY_EN
          state_nxt = WAIT;
`else
          state_nxt = RESP;
`endif
        end
      end
`ifdef L15_RESP_DELAY_EN
      WAIT: if (cnt_q == '0) state_nxt = RESP;
`endif
      RESP: if (rtrn_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Both banks are read in ACK so a full line is ready by the first RESP cycle.
  l15_resp_mem #(
    .RowsLog2(MemWordsLog2 - 1)
  ) u_mem (
    .clk       (clk_i),
    .rd_en     (state == ACK && (is_load || is_imiss)),
    .wr_en     (state == ACK && is_store),
    .wr_odd    (addr_q[3]),
    .row       (addr_q[MemWordsLog2+2:4]),
    .be        (byte_en(size_q, addr_q[2:0])),
    .wdata     (bswap64(data_q)),
    .rdata_even(rdata_even),
    .rdata_odd (rdata_odd)
  );

  assign req_ack_o = (state == ACK);
  assign err_o     = err_q;

  always_comb begin
    rtrn_val_o      = 1'b0;
    rtrn_rtntype_o  = '0;
    rtrn_threadid_o = '0;
    rtrn_data_0_o   = '0;
    rtrn_data_1_o   = '0;
    word_sel        = addr_q[3] ? rdata_odd : rdata_even;
    if (state == RESP) begin
      rtrn_val_o      = 1'b1;
      rtrn_threadid_o = tid_q;
      if (is_store) begin
        rtrn_rtntype_o = ST_ACK;
      end else begin
        rtrn_rtntype_o = is_imiss ? IFILL_RET : LOAD_RET;
        if (is_load && nc_q) begin
          rtrn_data_0_o = bswap64(word_sel);
          rtrn_data_1_o = bswap64(word_sel);
        end else begin
          rtrn_data_0_o = bswap64(rdata_even);
          rtrn_data_1_o = bswap64(rdata_odd);
        end
      end
    end
  end

endmodule

// File: tb/tb_l15_resp_stub.sv
// Scoreboard bench for l15_resp_stub: byte-array reference memory, expected
// returns queued at issue time and checked by an independent monitor.
module tb_l15_resp_stub;

`ifdef L15_RESP_DELAY_EN
  localparam int ExpLat = 2 + 4;
`else
  localparam int ExpLat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_val_i;
  logic        req_ack_o;
  logic [4:0]  req_rqtype_i;
  logic        req_nc_i;
  logic [2:0]  req_size_i;
  logic [1:0]  req_threadid_i;
  logic [39:0] req_address_i;
  logic [63:0] req_data_i;
  logic        rtrn_val_o;
  logic        rtrn_ack_i;
  logic [3:0]  rtrn_rtntype_o;
  logic [1:0]  rtrn_threadid_o;
  logic [63:0] rtrn_data_0_o;
  logic [63:0] rtrn_data_1_o;
  logic        err_o;

  l15_resp_stub #(
    .TidWidth(2),
    .PAddrWidth(40),
    .MemWordsLog2(14),
    .RespDelay(4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_val_i      (req_val_i),
    .req_ack_o      (req_ack_o),
    .req_rqtype_i   (req_rqtype_i),
    .req_nc_i       (req_nc_i),
    .req_size_i     (req_size_i),
    .req_threadid_i (req_threadid_i),
    .req_address_i  (req_address_i),
    .req_data_i     (req_data_i),
    .rtrn_val_o     (rtrn_val_o),
    .rtrn_ack_i     (rtrn_ack_i),
    .rtrn_rtntype_o (rtrn_rtntype_o),
    .rtrn_threadid_o(rtrn_threadid_o),
    .rtrn_data_0_o  (rtrn_data_0_o),
    .rtrn_data_1_o  (rtrn_data_1_o),
    .err_o          (err_o)
  );

  typedef struct packed {
    logic [3:0]  rtype;
    logic [1:0]  tid;
    logic [63:0] d0;
    logic [63:0] d1;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_active = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   ack_en = 0;
  bit   err_exp = 0;
  logic [7:0] mb [0:1023];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rtrn_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rtrn_ack_i = ack_en && ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no DUT event want event within bound (cycle %0d)", name, cyc);
  endtask

  // Monitor: each presented return is matched against the oldest expectation and re-checked every held cycle.
  initial forever begin
    @(negedge clk);
    if (rtrn_val_o) begin
      if (!cur_active) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rtrn: got type %h tid %h want no return", rtrn_rtntype_o, rtrn_threadid_o);
        end else begin
          cur = exp_q.pop_front();
          cur_active = 1;
        end
      end
      if (cur_active) begin
        check("rtntype", 64'(rtrn_rtntype_o), 64'(cur.rtype));
        check("threadid", 64'(rtrn_threadid_o), 64'(cur.tid));
        check("data_0", rtrn_data_0_o, cur.d0);
        check("data_1", rtrn_data_1_o, cur.d1);
      end
      if (rtrn_ack_i) cur_active = 0;
    end else begin
      cur_active = 0;
    end
  end

  function automatic logic [63:0] rd_word(input int unsigned base);
    logic [63:0] w;
    w = '0;
    for (int unsigned i = 0; i < 8; i++) w = {w[55:0], mb[(base + i) & 1023]};
    return w;
  endfunction

  // Requester-side replication of an n-byte big-endian value across all 8 lanes.
  function automatic logic [63:0] rep(input logic [63:0] v, input int unsigned sz);
    logic [63:0] r;
    int unsigned n;
    n = 1 << sz;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[63-8*i -: 8] = v[8*(n-1-(i % n)) +: 8];
    return r;
  endfunction

  task automatic issue(input logic [4:0] t, input logic nc, input logic [2:0] sz,
                       input logic [1:0] tid, input logic [39:0] a, input logic [63:0] d);
    exp_t e;
    int unsigned idx, n, st;
    idx = 32'(a[9:0]);
    e.tid = tid;
    e.d0 = '0;
    e.d1 = '0;
    case (t)
      5'b00000: begin
        e.rtype = 4'b0000;
        if (nc) begin
          e.d0 = rd_word(idx & ~32'd7);
          e.d1 = e.d0;
        end else begin
          e.d0 = rd_word(idx & ~32'd15);
          e.d1 = rd_word((idx & ~32'd15) + 8);
        end
        exp_q.push_back(e);
      end
      5'b10000: begin
        e.rtype = 4'b0001;
        e.d0 = rd_word(idx & ~32'd15);
        e.d1 = rd_word((idx & ~32'd15) + 8);
        exp_q.push_back(e);
      end
      5'b00001: begin
        n = 1 << sz;
        st = idx & ~(n - 1);
        for (int unsigned i = 0; i < n; i++) mb[st + i] = d[63-8*i -: 8];
        e.rtype = 4'b0100;
        exp_q.push_back(e);
      end
      default: err_exp = 1;
    endcase
    @(posedge clk);
    #1;
    req_rqtype_i   = t;
    req_nc_i       = nc;
    req_size_i     = sz;
    req_threadid_i = tid;
    req_address_i  = a;
    req_data_i     = d;
    req_val_i      = 1'b1;
  endtask

  task automatic wait_ack(input int unsigned bound);
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (req_ack_o) begin
        req_val_i = 1'b0;
        return;
      end
    end
    fail_timeout("req_ack_timeout");
    req_val_i = 1'b0;
  endtask

  task automatic do_req(input logic [4:0] t, input logic nc, input logic [2:0] sz,
                        input logic [1:0] tid, input logic [39:0] a, input logic [63:0] d);
    issue(t, nc, sz, tid, a, d);
    wait_ack(400);
  endtask

  task automatic wait_val(input int unsigned bound);
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rtrn_val_o) return;
    end
    fail_timeout("rtrn_val_timeout");
  endtask

  task automatic wait_drain(input int unsigned bound);
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rtrn_val_o) return;
    end
    fail_timeout("drain_timeout");
  endtask

  initial begin
    int k, ack_at, val_at;
    logic [4:0]  t;
    logic [39:0] a;
    int unsigned r, sz;

    rst_i = 1'b1;
    req_val_i = 1'b0;
    req_rqtype_i = '0;
    req_nc_i = 1'b0;
    req_size_i = '0;
    req_threadid_i = '0;
    req_address_i = '0;
    req_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_req_ack", 64'(req_ack_o), 64'd0);
    check("rst_rtrn_val", 64'(rtrn_val_o), 64'd0);
    check("rst_rtntype", 64'(rtrn_rtntype_o), 64'd0);
    check("rst_threadid", 64'(rtrn_threadid_o), 64'd0);
    check("rst_data_0", rtrn_data_0_o, 64'd0);
    check("rst_data_1", rtrn_data_1_o, 64'd0);
    check("rst_err", 64'(err_o), 64'd0);

    ack_en = 1;
    do_req(5'b00001, 1'b0, 3'd3, 2'd0, 40'h80, 64'h0011223344556677);
    do_req(5'b00000, 1'b1, 3'd3, 2'd1, 40'h80, 64'd0);
    do_req(5'b00001, 1'b0, 3'd3, 2'd0, 40'h88, 64'h8899AABBCCDDEEFF);
    do_req(5'b10000, 1'b0, 3'd4, 2'd2, 40'h88, 64'd0);
    do_req(5'b00001, 1'b0, 3'd3, 2'd0, 40'h80, 64'd0);
    do_req(5'b00001, 1'b0, 3'd0, 2'd3, 40'h83, rep(64'hAB, 0));
    do_req(5'b00000, 1'b1, 3'd3, 2'd1, 40'h80, 64'd0);

    // Latency from the sampling edge of req_val_i.
    wait_drain(200);
    issue(5'b00000, 1'b1, 3'd3, 2'd0, 40'h80, 64'd0);
    k = cyc;
    ack_at = -1;
    val_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ack_o && ack_at < 0) begin
        ack_at = cyc - k;
        req_val_i = 1'b0;
      end
      if (rtrn_val_o) begin
        val_at = cyc - k;
        break;
      end
    end
    if (req_val_i) req_val_i = 1'b0;
    check("ack_latency", 64'(ack_at), 64'(1));
    check("rtrn_latency", 64'(val_at), 64'(ExpLat));

    // Return held un-acked while a second request waits.
    wait_drain(200);
    ack_en = 0;
    do_req(5'b00000, 1'b1, 3'd3, 2'd1, 40'h80, 64'd0);
    wait_val(50);
    issue(5'b00000, 1'b0, 3'd4, 2'd3, 40'h88, 64'd0);
    repeat (10) begin
      @(negedge clk);
      check("ack_while_held", 64'(req_ack_o), 64'd0);
      check("val_while_held", 64'(rtrn_val_o), 64'd1);
    end
    ack_en = 1;
    wait_ack(400);

    // Unsupported request type.
    wait_drain(200);
    do_req(5'b00010, 1'b0, 3'd3, 2'd0, 40'h100, 64'd0);
    repeat (8) begin
      @(negedge clk);
      check("no_rtrn_unsupported", 64'(rtrn_val_o), 64'd0);
    end
    check("err_set", 64'(err_o), 64'(err_exp));

    // Reset while a return is pending.
    ack_en = 0;
    do_req(5'b00000, 1'b1, 3'd3, 2'd2, 40'h80, 64'd0);
    wait_val(50);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;
    err_exp = 0;
    check("rst_mid_rtrn_val", 64'(rtrn_val_o), 64'd0);
    check("rst_mid_err", 64'(err_o), 64'(err_exp));
    rst_i = 1'b0;
    ack_en = 1;
    do_req(5'b00000, 1'b1, 3'd3, 2'd2, 40'h80, 64'd0);

    // Fill the test window, then random traffic with aliased upper address bits.
    for (int unsigned w = 0; w < 128; w++) begin
      a = {23'($urandom), 7'd0, 7'(w), 3'd0};
      do_req(5'b00001, 1'b0, 3'd3, 2'($urandom), a, {$urandom, $urandom});
    end
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = {23'($urandom), 7'd0, 10'($urandom)};
      if (r <= 2) begin
        do_req(5'b00000, 1'b0, 3'($urandom_range(0, 4)), 2'($urandom), a, 64'd0);
      end else if (r <= 4) begin
        do_req(5'b00000, 1'b1, 3'($urandom_range(0, 3)), 2'($urandom), a, 64'd0);
      end else if (r == 5) begin
        do_req(5'b10000, 1'b0, 3'd4, 2'($urandom), a, 64'd0);
      end else if (r <= 8) begin
        sz = $urandom_range(0, 3);
        do_req(5'b00001, 1'b0, 3'(sz), 2'($urandom), a, rep({$urandom, $urandom}, sz));
      end else begin
        t = 5'($urandom);
        while (t == 5'b00000 || t == 5'b10000 || t == 5'b00001) t = 5'($urandom);
        do_req(t, 1'b0, 3'd3, 2'($urandom), a, 64'd0);
      end
    end
    wait_drain(3000);
    check("err_final", 64'(err_o), 64'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
